// File: rtl/alu_seq_if.sv
// Request/response valid-ready channel pair for the sequential ALU.
// master drives requests and takes responses; slave is the ALU.
interface alu_seq_if #(
    parameter int WIDTH = 4
);
    logic             req_valid;
    logic             req_ready;
    logic [WIDTH-1:0] req_a;
    logic [WIDTH-1:0] req_b;
    logic [2:0]       req_op;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_result;
    logic [WIDTH-1:0] rsp_hi;
    logic             rsp_carry;
    logic             rsp_zero;
    logic             rsp_err;

    modport master (
        output req_valid, req_a, req_b, req_op, rsp_ready,
        input  req_ready, rsp_valid, rsp_result, rsp_hi,
        input  rsp_carry, rsp_zero, rsp_err
    );

    modport slave (
        input  req_valid, req_a, req_b, req_op, rsp_ready,
        output req_ready, rsp_valid, rsp_result, rsp_hi,
        output rsp_carry, rsp_zero, rsp_err
    );
endinterface

// File: rtl/alu_seq.sv
// Handshaked sequential ALU; one transaction in flight at a time.
// ALU_MUL_EN enables the shift-add multiplier for op 111.
module alu_seq #(
    parameter int WIDTH = 4
) (
    input logic      clk,
    input logic      rst_n,
    alu_seq_if.slave bus
);
    localparam int SW = $clog2(WIDTH);

`ifdef ALU_MUL_EN
    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;
`else
    typedef enum logic {
        S_IDLE,
        S_DONE
    } state_t;
`endif

    state_t           r_state;
    logic             r_req_ready;
    logic             r_rsp_valid;
    logic [WIDTH-1:0] r_result;
    logic [WIDTH-1:0] r_hi;
    logic             r_carry;
    logic             r_zero;
    logic             r_err;

    logic             w_accept;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_diff;
    logic [WIDTH-1:0] w_res;
    logic             w_carry;
    logic             w_err;

`ifdef ALU_MUL_EN
    logic [2*WIDTH-1:0] r_acc;
    logic [2*WIDTH-1:0] r_mcd;
    logic [WIDTH-1:0]   r_mpl;
    logic [SW-1:0]      r_cnt;
    logic [2*WIDTH-1:0] w_acc_nxt;

    assign w_acc_nxt = r_mpl[0] ? r_acc + r_mcd : r_acc;
`endif

    assign w_accept = bus.req_valid && r_req_ready;
    assign w_sum    = {1'b0, bus.req_a} + {1'b0, bus.req_b};
    assign w_diff   = {1'b0, bus.req_a} - {1'b0, bus.req_b};

    always_comb begin
        w_res   = '0;
        w_carry = 1'b0;
        w_err   = 1'b0;
        unique case (bus.req_op)
            3'b000: begin
                w_res   = w_sum[WIDTH-1:0];
                w_carry = w_sum[WIDTH];
            end
            3'b001: begin
                w_res   = w_diff[WIDTH-1:0];
                w_carry = w_diff[WIDTH];
            end
            3'b010: w_res = bus.req_a & bus.req_b;
            3'b011: w_res = bus.req_a | bus.req_b;
            3'b100: w_res = bus.req_a ^ bus.req_b;
            3'b101: w_res = ~bus.req_a;
            3'b110: w_res = bus.req_a << bus.req_b[SW-1:0];
            // only reaches a response directly when no multiplier is built
            3'b111: w_err = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_result    <= '0;
            r_hi        <= '0;
            r_carry     <= 1'b0;
            r_zero      <= 1'b0;
            r_err       <= 1'b0;
`ifdef ALU_MUL_EN
            r_acc       <= '0;
            r_mcd       <= '0;
            r_mpl       <= '0;
            r_cnt       <= '0;
`endif
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_req_ready <= 1'b0;
`ifdef ALU_MUL_EN
                        if (bus.req_op == 3'b111) begin
                            r_state <= S_BUSY;
                            r_acc   <= '0;
                            r_mcd   <= {{WIDTH{1'b0}}, bus.req_a};
                            r_mpl   <= bus.req_b;
                            r_cnt   <= '0;
                        end else
`endif
                        begin
                            r_state     <= S_DONE;
                            r_rsp_valid <= 1'b1;
                            r_result    <= w_res;
                            r_hi        <= '0;
                            r_carry     <= w_carry;
                            r_zero      <= (w_res == '0);
                            r_err       <= w_err;
                        end
                    end
                end
`ifdef ALU_MUL_EN
                S_BUSY: begin
                    r_acc <= w_acc_nxt;
                    r_mcd <= r_mcd << 1;
                    r_mpl <= r_mpl >> 1;
                    r_cnt <= r_cnt + 1'b1;
                    // last multiplier bit folds straight into the response
                    if (r_cnt == SW'(WIDTH - 1)) begin
                        r_state     <= S_DONE;
                        r_rsp_valid <= 1'b1;
                        r_result    <= w_acc_nxt[WIDTH-1:0];
                        r_hi        <= w_acc_nxt[2*WIDTH-1:WIDTH];
                        r_carry     <= 1'b0;
                        r_zero      <= (w_acc_nxt[WIDTH-1:0] == '0);
                        r_err       <= 1'b0;
                    end
                end
`endif
                S_DONE: begin
                    if (bus.rsp_ready) begin
                        r_state     <= S_IDLE;
                        r_rsp_valid <= 1'b0;
                        r_req_ready <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.req_ready  = r_req_ready;
    assign bus.rsp_valid  = r_rsp_valid;
    assign bus.rsp_result = r_result;
    assign bus.rsp_hi     = r_hi;
    assign bus.rsp_carry  = r_carry;
    assign bus.rsp_zero   = r_zero;
    assign bus.rsp_err    = r_err;
endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed table, corner sequences,
// and random transactions against an arithmetic reference model.
module tb_alu_seq;
    localparam int W   = 4;
    localparam int MOD = 1 << W;
`ifdef ALU_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_seq_if #(.WIDTH(W)) bus ();

    alu_seq #(.WIDTH(W)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [W-1:0] res;
        logic [W-1:0] hi;
        logic         carry;
        logic         zero;
        logic         err;
    } rsp_t;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [2:0]   op;
        rsp_t         exp;
        int           hold;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic rsp_t mk_rsp(input logic [W-1:0] res,
                                    input logic [W-1:0] hi,
                                    input logic c, input logic z,
                                    input logic e);
        rsp_t r;
        r.res = res; r.hi = hi; r.carry = c; r.zero = z; r.err = e;
        return r;
    endfunction

    function automatic vec_t mk_vec(input logic [W-1:0] a,
                                    input logic [W-1:0] b,
                                    input logic [2:0] op,
                                    input rsp_t e, input int hold);
        vec_t v;
        v.a = a; v.b = b; v.op = op; v.exp = e; v.hold = hold;
        return v;
    endfunction

    function automatic rsp_t model(input logic [W-1:0] a,
                                   input logic [W-1:0] b,
                                   input logic [2:0] op);
        rsp_t r;
        int unsigned ua;
        int unsigned ub;
        int unsigned full;
        ua = a;
        ub = b;
        r  = mk_rsp('0, '0, 1'b0, 1'b0, 1'b0);
        case (op)
            3'd0: begin
                full    = ua + ub;
                r.res   = W'(full % MOD);
                r.carry = (full >= MOD);
            end
            3'd1: begin
                r.res   = W'((ua + MOD - ub) % MOD);
                r.carry = (ua < ub);
            end
            3'd2: r.res = a & b;
            3'd3: r.res = a | b;
            3'd4: r.res = a ^ b;
            3'd5: r.res = ~a;
            3'd6: r.res = W'((ua << (ub % W)) % MOD);
            default: begin
`ifdef ALU_MUL_EN
                full = ua * ub;
                r.res = W'(full % MOD);
                r.hi  = W'(full / MOD);
`else
                r.err = 1'b1;
`endif
            end
        endcase
        r.zero = (r.res == '0);
        return r;
    endfunction

    task automatic expect_rsp(input string tag, input rsp_t e);
        check({tag, " valid"}, bus.rsp_valid, 1'b1);
        check({tag, " rdy"}, bus.req_ready, 1'b0);
        check({tag, " res"}, bus.rsp_result, e.res);
        check({tag, " hi"}, bus.rsp_hi, e.hi);
        check({tag, " carry"}, bus.rsp_carry, e.carry);
        check({tag, " zero"}, bus.rsp_zero, e.zero);
        check({tag, " err"}, bus.rsp_err, e.err);
    endtask

    task automatic run_txn(input string tag, input logic [W-1:0] a,
                           input logic [W-1:0] b, input logic [2:0] op,
                           input rsp_t e, input int hold, input bit early);
        int lat;
        int exp_lat;
        exp_lat = (op == 3'b111 && MUL_EN) ? W + 1 : 1;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_a     = a;
        bus.req_b     = b;
        bus.req_op    = op;
        check({tag, " idle rdy"}, bus.req_ready, 1'b1);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        bus.req_a     = W'($urandom);
        bus.req_b     = W'($urandom);
        bus.req_op    = 3'($urandom);
        if (early) bus.rsp_ready = 1'b1;
        lat = 1;
        while (!bus.rsp_valid && lat < 50) begin
            check({tag, " busy rdy"}, bus.req_ready, 1'b0);
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, " latency"}, lat, exp_lat);
        expect_rsp(tag, e);
        if (!early) begin
            for (int h = 0; h < hold; h++) begin
                @(negedge clk);
                bus.req_valid = 1'b1;
                bus.req_a     = W'($urandom);
                bus.req_op    = 3'($urandom);
                @(posedge clk);
                #1;
                expect_rsp({tag, " held"}, e);
            end
            @(negedge clk);
            bus.rsp_ready = 1'b1;
            @(posedge clk);
        end else begin
            @(posedge clk);
        end
        #1;
        bus.rsp_ready = 1'b0;
        bus.req_valid = 1'b0;
        check({tag, " drop valid"}, bus.rsp_valid, 1'b0);
        check({tag, " back rdy"}, bus.req_ready, 1'b1);
    endtask

    vec_t tbl[12];

    initial begin
        bus.req_valid = 1'b0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.req_op    = '0;
        bus.rsp_ready = 1'b0;

        tbl[0]  = mk_vec(4'h2, 4'h1, 3'd0, mk_rsp(4'h3, 4'h0, 0, 0, 0), 3);
        tbl[1]  = mk_vec(4'hA, 4'hC, 3'd2, mk_rsp(4'h8, 4'h0, 0, 0, 0), 0);
        tbl[2]  = mk_vec(4'h1, 4'h2, 3'd1, mk_rsp(4'hF, 4'h0, 1, 0, 0), 0);
        tbl[3]  = mk_vec(4'h5, 4'h5, 3'd4, mk_rsp(4'h0, 4'h0, 0, 1, 0), 0);
        tbl[4]  = mk_vec(4'hF, 4'h1, 3'd0, mk_rsp(4'h0, 4'h0, 1, 1, 0), 0);
        tbl[5]  = mk_vec(4'h3, 4'h3, 3'd1, mk_rsp(4'h0, 4'h0, 0, 1, 0), 0);
        tbl[6]  = mk_vec(4'h5, 4'hA, 3'd3, mk_rsp(4'hF, 4'h0, 0, 0, 0), 0);
        tbl[7]  = mk_vec(4'h6, 4'h0, 3'd5, mk_rsp(4'h9, 4'h0, 0, 0, 0), 0);
        tbl[8]  = mk_vec(4'h3, 4'h2, 3'd6, mk_rsp(4'hC, 4'h0, 0, 0, 0), 0);
        tbl[9]  = mk_vec(4'h3, 4'h7, 3'd6, mk_rsp(4'h8, 4'h0, 0, 0, 0), 1);
`ifdef ALU_MUL_EN
        tbl[10] = mk_vec(4'hF, 4'hF, 3'd7, mk_rsp(4'h1, 4'hE, 0, 0, 0), 3);
        tbl[11] = mk_vec(4'h4, 4'h4, 3'd7, mk_rsp(4'h0, 4'h1, 0, 1, 0), 0);
`else
        tbl[10] = mk_vec(4'hF, 4'hF, 3'd7, mk_rsp(4'h0, 4'h0, 0, 1, 1), 3);
        tbl[11] = mk_vec(4'h4, 4'h4, 3'd7, mk_rsp(4'h0, 4'h0, 0, 1, 1), 0);
`endif

        // reset held while inputs wiggle
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus.req_valid = 1'b1;
            bus.req_a     = W'($urandom);
            bus.req_b     = W'($urandom);
            bus.req_op    = 3'($urandom);
            bus.rsp_ready = 1'($urandom);
        end
        @(negedge clk);
        check("rst rdy", bus.req_ready, 1'b1);
        check("rst valid", bus.rsp_valid, 1'b0);
        check("rst res", bus.rsp_result, 0);
        check("rst hi", bus.rsp_hi, 0);
        check("rst carry", bus.rsp_carry, 1'b0);
        check("rst zero", bus.rsp_zero, 1'b0);
        check("rst err", bus.rsp_err, 1'b0);
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b0;
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++)
            run_txn($sformatf("vec%0d", i), tbl[i].a, tbl[i].b,
                    tbl[i].op, tbl[i].exp, tbl[i].hold, 1'b0);

        // reset while a response is pending
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_a     = 4'hF;
        bus.req_b     = 4'h1;
        bus.req_op    = 3'd0;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        check("rdone valid", bus.rsp_valid, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rdone clr valid", bus.rsp_valid, 1'b0);
        check("rdone clr carry", bus.rsp_carry, 1'b0);
        check("rdone clr zero", bus.rsp_zero, 1'b0);
        check("rdone clr rdy", bus.req_ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;

`ifdef ALU_MUL_EN
        // reset in the third multiply cycle
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_a     = 4'hF;
        bus.req_b     = 4'hF;
        bus.req_op    = 3'd7;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        check("rbusy rdy pre", bus.req_ready, 1'b0);
        rst_n = 1'b0;
        #1;
        check("rbusy valid", bus.rsp_valid, 1'b0);
        check("rbusy rdy", bus.req_ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
`endif
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("post rst quiet", bus.rsp_valid, 1'b0);
            check("post rst rdy", bus.req_ready, 1'b1);
        end

        for (int i = 0; i < 200; i++) begin
            logic [W-1:0] a;
            logic [W-1:0] b;
            logic [2:0]   op;
            a  = W'($urandom);
            b  = W'($urandom);
            op = 3'($urandom);
            run_txn($sformatf("rnd%0d", i), a, b, op, model(a, b, op),
                    int'($urandom_range(0, 2)), 1'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
